board_read_arbiter: RTL



---
 rtl/board_read_arbiter_pkg.sv | 31 +++
 rtl/board_read_arbiter_starve_counter.sv | 34 +++
 rtl/board_read_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/board_read_arbiter_pkg.sv
// Shared encodings for the board read-port arbiter: cell values, address widths,
// arbiter state and round-robin pointer.
package board_read_arbiter_pkg;

  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int CELL_W = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [CELL_W-1:0] {
    EMPTY   = 2'b00,
    PLAYER1 = 2'b01,
    PLAYER2 = 2'b10
  } cell_e;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    RR_DISP = 1'b0,
    RR_AUX  = 1'b1
  } rr_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } addr_t;

endpackage

// File: rtl/board_read_arbiter_starve_counter.sv
// Saturating wait counter for one low-priority requester; flags starvation once
// the requester has been denied LIMIT consecutive cycles.
module board_read_arbiter_starve_counter
  import board_read_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic starved_o
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (req_i && !gnt_i)
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // >= rather than == so a count that kept climbing while the checker held the
  // port still forces the requester through once the lock is released.
  assign starved_o = req_i && (cnt_q >= LIM);

endmodule

// File: rtl/board_read_arbiter.sv
// Three-way arbiter for the single board read port: checker (with burst lock),
// display scan and aux, with starvation escape and a one-cycle read return.
module board_read_arbiter
  import board_read_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_req,
  input  logic             chk_lock,
  input  logic [ROW_W-1:0] chk_row,
  input  logic [COL_W-1:0] chk_col,
  input  logic             disp_req,
  input  logic [ROW_W-1:0] disp_row,
  input  logic [COL_W-1:0] disp_col,
  input  logic             aux_req,
  input  logic [ROW_W-1:0] aux_row,
  input  logic [COL_W-1:0] aux_col,
  output logic             chk_gnt,
  output logic             disp_gnt,
  output logic             aux_gnt,
  output logic             chk_rvalid,
  output logic             disp_rvalid,
  output logic             aux_rvalid,
  output logic [CELL_W-1:0] rdata,
  output logic             mem_rd_en,
  output logic [ROW_W-1:0] mem_r_row,
  output logic [COL_W-1:0] mem_r_col,
  input  logic [CELL_W-1:0] mem_data
);

  arb_state_e        state_q, state_d;
  rr_e               rr_q, rr_d;
  logic [2:0]        rvld_q;
  logic [CELL_W-1:0] rdata_q;
  logic              disp_starved, aux_starved, lock_hold;
  addr_t             mem_a;

  board_read_arbiter_starve_counter #(.LIMIT(STARVE_LIMIT)) u_disp_starve (
    .clk(clk), .rst_n(rst_n), .req_i(disp_req), .gnt_i(disp_gnt), .starved_o(disp_starved)
  );

  board_read_arbiter_starve_counter #(.LIMIT(STARVE_LIMIT)) u_aux_starve (
    .clk(clk), .rst_n(rst_n), .req_i(aux_req), .gnt_i(aux_gnt), .starved_o(aux_starved)
  );

  // Dropping chk_lock releases the port in that same cycle.
  assign lock_hold = (state_q == ST_LOCKED) && chk_lock;

  always_comb begin
    chk_gnt  = 1'b0;
    disp_gnt = 1'b0;
    aux_gnt  = 1'b0;
    if (lock_hold)               chk_gnt  = chk_req;
    else if (disp_starved)       disp_gnt = 1'b1;
    else if (aux_starved)        aux_gnt  = 1'b1;
    else if (chk_req)            chk_gnt  = 1'b1;
    else if (disp_req && aux_req) begin
      if (rr_q == RR_DISP)       disp_gnt = 1'b1;
      else                       aux_gnt  = 1'b1;
    end
    else if (disp_req)           disp_gnt = 1'b1;
    else if (aux_req)            aux_gnt  = 1'b1;
  end

  always_comb begin
    mem_a = '0;
    if (chk_gnt)       mem_a = '{row: chk_row,  col: chk_col};
    else if (disp_gnt) mem_a = '{row: disp_row, col: disp_col};
    else if (aux_gnt)  mem_a = '{row: aux_row,  col: aux_col};
  end

  assign mem_rd_en = chk_gnt | disp_gnt | aux_gnt;
  assign mem_r_row = mem_a.row;
  assign mem_r_col = mem_a.col;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN:   if (chk_gnt && chk_lock) state_d = ST_LOCKED;
      ST_LOCKED: if (!chk_lock)           state_d = ST_OPEN;
      default:                            state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (disp_gnt)     rr_d = RR_AUX;
    else if (aux_gnt) rr_d = RR_DISP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OPEN;
      rr_q    <= RR_DISP;
      rvld_q  <= '0;
      rdata_q <= EMPTY;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      rvld_q  <= {chk_gnt, disp_gnt, aux_gnt};
      rdata_q <= rdata;
    end
  end

  assign chk_rvalid  = rvld_q[2];
  assign disp_rvalid = rvld_q[1];
  assign aux_rvalid  = rvld_q[0];
  // Memory data lands the cycle after the address, so it passes straight through on return.
  assign rdata       = (|rvld_q) ? mem_data : rdata_q;

endmodule
